// File: rtl/match_timer_ctrl.sv
// Match-length timer controller for the pong game: set-time menu adjustment,
// 1 Hz countdown with pause/resume, and match end on time-out or game-over.
module match_timer_ctrl #(
    parameter int CLK_HZ       = 100000000,
    parameter int STEP         = 10,
    parameter int MIN_TIME     = 30,
    parameter int MAX_TIME     = 240,
    parameter int DEFAULT_TIME = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_start,
    input  logic       game_over,
    output logic [7:0] max_time,
    output logic [7:0] time_left,
    output logic [1:0] state,
    output logic       running,
    output logic       sec_tick,
    output logic       time_up
);

    localparam int              PW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(CLK_HZ - 1);
    localparam logic [8:0]      STEP9      = 9'(STEP);
    localparam logic [8:0]      MIN9       = 9'(MIN_TIME);
    localparam logic [8:0]      MAX9       = 9'(MAX_TIME);
    localparam logic [7:0]      DEFAULT8   = 8'(DEFAULT_TIME);

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    max_time_q, max_time_d;
    logic [7:0]    time_left_q, time_left_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          running_q, running_d;
    logic          sec_tick_q, sec_tick_d;
    logic          time_up_q, time_up_d;
    logic          up_prev_q, down_prev_q, start_prev_q;

    logic       up_press, down_press, start_press;
    logic       tick;
    logic [8:0] up_sum, down_diff;
    logic [7:0] max_adj;

    assign up_press    = btn_up    & ~up_prev_q;
    assign down_press  = btn_down  & ~down_prev_q;
    assign start_press = btn_start & ~start_prev_q;
    assign tick        = (presc_q == PRESC_LAST);

    // Saturating adjustment done in 9 bits so neither bound can wrap.
    always_comb begin
        up_sum    = {1'b0, max_time_q} + STEP9;
        down_diff = {1'b0, max_time_q} - STEP9;
        max_adj   = max_time_q;
        if (up_press && !down_press) begin
            max_adj = (up_sum > MAX9) ? MAX9[7:0] : up_sum[7:0];
        end else if (down_press && !up_press) begin
            max_adj = ({1'b0, max_time_q} < (MIN9 + STEP9)) ? MIN9[7:0] : down_diff[7:0];
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        state_d     = state_q;
        max_time_d  = max_time_q;
        time_left_d = time_left_q;
        presc_d     = presc_q;
        sec_tick_d  = 1'b0;
        time_up_d   = 1'b0;

        unique case (state_q)
            ST_SET: begin
                max_time_d  = max_adj;
                time_left_d = max_adj;
                if (start_press) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end
            end

            ST_RUN: begin
                if (game_over) begin
                    state_d = ST_DONE;
                end else if (tick && (time_left_q == 8'd1)) begin
                    // Final decrement wins even over a simultaneous start press.
                    state_d     = ST_DONE;
                    presc_d     = '0;
                    time_left_d = 8'd0;
                    sec_tick_d  = 1'b1;
                    time_up_d   = 1'b1;
                end else if (start_press) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    presc_d     = '0;
                    time_left_d = time_left_q - 8'd1;
                    sec_tick_d  = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end

            ST_PAUSE: begin
                if (game_over) begin
                    state_d = ST_DONE;
                end else if (start_press) begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                if (start_press) begin
                    state_d     = ST_SET;
                    time_left_d = max_time_q;
                end
            end

            default: state_d = ST_SET;
        endcase

        running_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q      <= ST_SET;
            max_time_q   <= DEFAULT8;
            time_left_q  <= DEFAULT8;
            presc_q      <= '0;
            running_q    <= 1'b0;
            sec_tick_q   <= 1'b0;
            time_up_q    <= 1'b0;
            // Buttons held through reset must be released before they count.
            up_prev_q    <= 1'b1;
            down_prev_q  <= 1'b1;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            max_time_q   <= max_time_d;
            time_left_q  <= time_left_d;
            presc_q      <= presc_d;
            running_q    <= running_d;
            sec_tick_q   <= sec_tick_d;
            time_up_q    <= time_up_d;
            up_prev_q    <= btn_up;
            down_prev_q  <= btn_down;
            start_prev_q <= btn_start;
        end
    end

    assign max_time  = max_time_q;
    assign time_left = time_left_q;
    assign state     = state_q;
    assign running   = running_q;
    assign sec_tick  = sec_tick_q;
    assign time_up   = time_up_q;

endmodule

// File: tb/tb_match_timer_ctrl.sv
// Directed bench for match_timer_ctrl; expectations queued at drive time and
// checked against the registered outputs one edge later.
module tb_match_timer_ctrl;

    localparam int CLK_HZ = 4;
    localparam int S_SET = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic       clk = 1'b0;
    logic       reset, btn_up, btn_down, btn_start, game_over;
    logic [7:0] max_time, time_left;
    logic [1:0] state;
    logic       running, sec_tick, time_up;

    match_timer_ctrl #(
        .CLK_HZ(CLK_HZ), .STEP(10), .MIN_TIME(30), .MAX_TIME(240), .DEFAULT_TIME(60)
    ) dut (
        .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .btn_start(btn_start), .game_over(game_over), .max_time(max_time),
        .time_left(time_left), .state(state), .running(running),
        .sec_tick(sec_tick), .time_up(time_up)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] mt;
        logic [7:0] tl;
        logic [1:0] st;
        logic       run;
        logic       tick;
        logic       tu;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   m_mt, m_tl, m_presc;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check_field(input string tag, input string f,
                               input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s: got %0d expected %0d", tag, f, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int mt, input int tl, input int st,
                        input int run, input int tick, input int tu);
        exp_t e;
        e.tag  = tag;
        e.mt   = 8'(mt);
        e.tl   = 8'(tl);
        e.st   = 2'(st);
        e.run  = 1'(run);
        e.tick = 1'(tick);
        e.tu   = 1'(tu);
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            check_field(e.tag, "max_time",  max_time,        e.mt);
            check_field(e.tag, "time_left", time_left,       e.tl);
            check_field(e.tag, "state",     {6'd0, state},   {6'd0, e.st});
            check_field(e.tag, "running",   {7'd0, running}, {7'd0, e.run});
            check_field(e.tag, "sec_tick",  {7'd0, sec_tick}, {7'd0, e.tick});
            check_field(e.tag, "time_up",   {7'd0, time_up}, {7'd0, e.tu});
        end
    endtask

    task automatic step_expect(input string tag, input int mt, input int tl, input int st,
                               input int run, input int tick, input int tu);
        push(tag, mt, tl, st, run, tick, tu);
        cyc();
        compare();
    endtask

    task automatic press_up(input string tag);
        btn_up = 1'b1;
        m_mt = (m_mt + 10 > 240) ? 240 : m_mt + 10;
        m_tl = m_mt;
        step_expect(tag, m_mt, m_tl, S_SET, 0, 0, 0);
        btn_up = 1'b0;
        cyc();
    endtask

    task automatic press_down(input string tag);
        btn_down = 1'b1;
        m_mt = (m_mt - 10 < 30) ? 30 : m_mt - 10;
        m_tl = m_mt;
        step_expect(tag, m_mt, m_tl, S_SET, 0, 0, 0);
        btn_down = 1'b0;
        cyc();
    endtask

    // Start press from SET: countdown begins from max_time with a fresh second.
    task automatic start_from_set(input string tag);
        btn_start = 1'b1;
        m_tl = m_mt;
        m_presc = 0;
        step_expect(tag, m_mt, m_tl, S_RUN, 1, 0, 0);
        btn_start = 1'b0;
    endtask

    // One RUN cycle with no buttons: a second elapses every CLK_HZ cycles.
    task automatic run_cyc(input string tag);
        bit t;
        t = (m_presc == CLK_HZ - 1);
        if (t) begin
            m_presc = 0;
            m_tl--;
        end else begin
            m_presc++;
        end
        if (t && m_tl == 0) step_expect(tag, m_mt, 0, S_DONE, 0, 1, 1);
        else                step_expect(tag, m_mt, m_tl, S_RUN, 1, int'(t), 0);
    endtask

    initial begin
        reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_start = 1'b0; game_over = 1'b0;
        m_mt = 60; m_tl = 60; m_presc = 0;

        step_expect("reset", 60, 60, S_SET, 0, 0, 0);
        reset = 1'b0;
        step_expect("post_reset", 60, 60, S_SET, 0, 0, 0);

        // Adjust up, then saturate at the ceiling.
        for (int i = 0; i < 3; i++) press_up("up");
        step_expect("up_90", 90, 90, S_SET, 0, 0, 0);
        for (int i = 0; i < 20; i++) press_up("up_sat");
        step_expect("up_240", 240, 240, S_SET, 0, 0, 0);

        // Back to default, then floor at the minimum.
        reset = 1'b1;
        m_mt = 60; m_tl = 60;
        step_expect("reset2", 60, 60, S_SET, 0, 0, 0);
        reset = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) press_down("down");
        step_expect("down_30", 30, 30, S_SET, 0, 0, 0);
        btn_up = 1'b1; btn_down = 1'b1;
        step_expect("up_down_same", 30, 30, S_SET, 0, 0, 0);
        btn_up = 1'b0; btn_down = 1'b0;
        cyc();

        // Full countdown from 30 s: 120 cycles to DONE.
        start_from_set("start_30");
        for (int k = 1; k <= 120; k++) run_cyc("countdown");
        step_expect("done_hold", 30, 0, S_DONE, 0, 0, 0);

        btn_start = 1'b1;
        m_tl = m_mt;
        step_expect("done_to_set", 30, 30, S_SET, 0, 0, 0);
        btn_start = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) press_up("up_to_60");

        // Pause after 6 cycles with prescaler at 2, hold, then resume.
        start_from_set("start_60");
        for (int k = 1; k <= 6; k++) run_cyc("pre_pause");
        btn_start = 1'b1;
        step_expect("pause", 60, 59, S_PAUSE, 0, 0, 0);
        btn_start = 1'b0;
        for (int i = 0; i < 50; i++) step_expect("pause_hold", 60, 59, S_PAUSE, 0, 0, 0);
        btn_start = 1'b1;
        step_expect("resume", 60, 59, S_RUN, 1, 0, 0);
        btn_start = 1'b0;
        step_expect("resume_1", 60, 59, S_RUN, 1, 0, 0);
        step_expect("resume_2_tick", 60, 58, S_RUN, 1, 1, 0);
        m_presc = 0; m_tl = 58;
        while (m_tl != 45) run_cyc("run_to_45");

        // Game over ends the match without time_up and holds time_left.
        game_over = 1'b1;
        step_expect("game_over", 60, 45, S_DONE, 0, 0, 0);
        step_expect("game_over_hold", 60, 45, S_DONE, 0, 0, 0);
        game_over = 1'b0;
        step_expect("done_after_go", 60, 45, S_DONE, 0, 0, 0);
        btn_start = 1'b1;
        m_tl = m_mt;
        step_expect("go_to_set", 60, 60, S_SET, 0, 0, 0);
        btn_start = 1'b0;
        cyc();

        // Reset mid-RUN with start held: ignored until released and pressed again.
        press_up("up_70");
        start_from_set("start_70");
        for (int k = 1; k <= 5; k++) run_cyc("pre_reset");
        reset = 1'b1; btn_start = 1'b1;
        m_mt = 60; m_tl = 60;
        step_expect("reset_mid_run", 60, 60, S_SET, 0, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step_expect("start_held", 60, 60, S_SET, 0, 0, 0);
        btn_start = 1'b0;
        step_expect("start_released", 60, 60, S_SET, 0, 0, 0);
        start_from_set("start_repress");

        // Final tick coinciding with a start press still ends the match.
        while (!(m_tl == 1 && m_presc == CLK_HZ - 1)) run_cyc("run_to_1");
        btn_start = 1'b1;
        step_expect("tick_beats_start", 60, 0, S_DONE, 0, 1, 1);
        btn_start = 1'b0;
        step_expect("pulses_clear", 60, 0, S_DONE, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/match_timer_ctrl.md
# match_timer_ctrl

Controller for the match-length timer of the pong game. In the set-time menu it adjusts the configured match length from push-buttons. It feeds that value to the set-time display and the minute/second conversion logic. During play it counts the remaining time down at 1 Hz, handles pause/resume, and ends the match on time-out or on an external game-over.

## Interface
Parameters:
- CLK_HZ, 100000000: clock cycles per second tick; benches override with a small value.
- STEP, 10: seconds added or removed per button press.
- MIN_TIME, 30: lower saturation bound for max_time.
- MAX_TIME, 240: upper saturation bound; must be ≤ 255.
- DEFAULT_TIME, 60: max_time after reset; MIN_TIME ≤ DEFAULT_TIME ≤ MAX_TIME.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- btn_up  in  1  debounced level; raises match length.
- btn_down  in  1  debounced level; lowers match length.
- btn_start  in  1  debounced level; start / pause / resume / back-to-menu.
- game_over  in  1  level from score logic; ends the match early.
- max_time  out  8  configured match length in seconds, to the set-time display.
- time_left  out  8  remaining seconds.
- state  out  2  0=SET, 1=RUN, 2=PAUSE, 3=DONE.
- running  out  1  high only in RUN; gates ball/paddle motion.
- sec_tick  out  1  one-cycle pulse on each decrement of time_left.
- time_up  out  1  one-cycle pulse when time_left reaches 0.

## Operation
- Button edges:
  - Each button has an edge detector: press = level high while the previous-cycle register is low.
  - The previous-cycle registers reset to 1, so a button held through reset is ignored until it is released and pressed again.
- SET:
  - Up press sets max_time = min(max_time+STEP, MAX_TIME).
  - Down press sets max_time = max(max_time−STEP, MIN_TIME).
  - Arithmetic is 9-bit internally, so no wrap occurs.
  - Up and down pressed in the same cycle: no change.
  - time_left follows max_time, updating on the same edge.
  - Start press: go to RUN, set time_left = max_time, clear the prescaler.
- RUN:
  - The prescaler counts 0..CLK_HZ−1; its wrap is the tick.
  - On a tick, time_left decrements and sec_tick pulses.
  - If the decrement takes time_left from 1 to 0, the state goes to DONE and time_up pulses.
  - Start press: go to PAUSE.
- PAUSE:
  - The prescaler and time_left are frozen; the prescaler value is kept.
  - Start press: go to RUN, counting resumes from the held prescaler value.
- DONE:
  - time_left holds its value.
  - Start press: go to SET, set time_left = max_time.
- game_over (level) in RUN or PAUSE: go to DONE. time_up is not asserted, and time_left is held.
- Priority within one cycle: game_over > start press > tick.
  - Exception: a tick that reaches 0 in the same cycle as a start press goes to DONE with time_up asserted.
- Up and down presses are ignored outside SET.

## Timing
- All outputs are registered and update on the clk edge after the causing input or tick.
- Reset values:
  - state = SET, max_time = time_left = DEFAULT_TIME.
  - running = 0, sec_tick = 0, time_up = 0, prescaler = 0.
- Latency:
  - Button press to max_time or state change: 1 cycle after the level rises.
  - running changes on the same edge as state.
- Tick spacing: first decrement after RUN entry from SET occurs exactly CLK_HZ cycles after entry, then every CLK_HZ cycles.
- Pulse outputs:
  - time_up and sec_tick are coincident on the final decrement.
  - Each is high for exactly 1 cycle.
- Reset mid-operation: return to reset values on the next edge regardless of state.

## Test plan
- Adjust up: reset, then 3 up presses → max_time 60→90, time_left = 90. Then 20 more up presses → max_time saturates at 240.
- Adjust down: from 60, 5 down presses → 30 (floor). Up and down pressed in the same cycle → max_time unchanged.
- Full countdown: CLK_HZ=4, max_time=30, start.
  - time_left decrements every 4 cycles.
  - 120 cycles after RUN entry: time_left = 0, state = DONE, single-cycle time_up coincident with sec_tick, running = 0.
- Pause/resume: CLK_HZ=4, max_time=60.
  - Start, wait 6 cycles (time_left 59, prescaler at 2), press start → PAUSE.
  - Hold 50 cycles: time_left stays 59.
  - Resume: next sec_tick comes 2 cycles after RUN re-entry.
- Game over: in RUN at time_left 45, raise game_over → DONE, time_up stays 0, time_left = 45. Start press → SET, time_left = max_time.
- Reset mid-RUN with btn_start held:
  - → SET, max_time = 60, no state change while btn_start stays high.
  - After release and re-press → RUN.
